// File: rtl/lcd_pkg.sv
// Shared constants for the LCD SPI arbiter: FSM encodings and default sizing.
package lcd_pkg;

    localparam int NREQ_DEFAULT    = 3;
    localparam int TIMEOUT_DEFAULT = 1024;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_ARB   = 3'd1;
    localparam logic [2:0] ST_XFER  = 3'd2;
    localparam logic [2:0] ST_DRAIN = 3'd3;
    localparam logic [2:0] ST_GAP   = 3'd4;

endpackage

// File: rtl/rr_pick.sv
// Round-robin picker: first set bit of req at or after ptr, wrapping, as a one-hot grant.
module rr_pick
    import lcd_pkg::*;
#(
    parameter int NREQ = NREQ_DEFAULT,
    parameter int PW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic [NREQ-1:0] req,
    input  logic [PW-1:0]   ptr,
    output logic [NREQ-1:0] gnt
);

    logic          w_found;
    logic [PW-1:0] w_idx;

    always_comb begin
        gnt     = '0;
        w_found = 1'b0;
        w_idx   = '0;
        for (int i = 0; i < NREQ; i++) begin
            w_idx = PW'((int'(ptr) + i) % NREQ);
            if (!w_found && req[w_idx]) begin
                gnt[w_idx] = 1'b1;
                w_found    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/lcd_spi_arbiter.sv
// Shares one spi_master among NREQ LCD byte streams with burst-locked round-robin grants.
//
//   state | meaning
//   IDLE  | no owner; waits for any request
//   ARB   | picks next requester round-robin and registers its grant
//   XFER  | owner's bytes pass through to spi_master; stall timer runs
//   DRAIN | start held low until spi_master stops shifting
//   GAP   | one idle cycle so the LCD sees chip-enable deselected
module lcd_spi_arbiter
    import lcd_pkg::*;
#(
    parameter int NREQ    = NREQ_DEFAULT,
    parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
    input  logic              clock,
    input  logic              Reset,
    input  logic [NREQ-1:0]   req_valid,
    input  logic [8*NREQ-1:0] req_data,
    input  logic [NREQ-1:0]   req_dc,
    input  logic [NREQ-1:0]   req_last,
    output logic [NREQ-1:0]   req_ready,
    output logic [NREQ-1:0]   grant,
    output logic [7:0]        spi_data,
    output logic              spi_start,
    output logic              spi_command,
    input  logic              spi_avail,
    input  logic              spi_busy,
    output logic              abort_err
);

    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int SW = $clog2(TIMEOUT + 1);

    logic [2:0]      r_state;
    logic [2:0]      w_state_nxt;
    logic [NREQ-1:0] r_grant;
    logic [NREQ-1:0] w_pick;
    logic [NREQ-1:0] w_grant_nxt;
    logic [PW-1:0]   r_ptr;
    logic [PW-1:0]   w_gidx;
    logic [PW-1:0]   w_ptr_nxt;
    logic [SW-1:0]   r_stall;
    logic            r_abort;
    logic            r_spi_start;
    logic [1:0]      r_rst_sync;
    logic [7:0]      w_data;
    logic            w_cmd;
    logic            w_any;
    logic            w_gvalid;
    logic            w_glast;
    logic            w_consume;
    logic            w_stall;
    logic            w_timeout;

    rr_pick #(
        .NREQ (NREQ),
        .PW   (PW)
    ) u_rr_pick (
        .req (req_valid),
        .ptr (r_ptr),
        .gnt (w_pick)
    );

    assign w_any     = |req_valid;
    assign w_gvalid  = |(req_valid & r_grant);
    assign w_glast   = |(req_last & r_grant);
    assign w_consume = (r_state == ST_XFER) && w_gvalid && spi_avail;
    assign w_stall   = (r_state == ST_XFER) && !w_gvalid;
    assign w_timeout = w_stall && (r_stall == SW'(TIMEOUT - 1));

    always_comb begin
        w_gidx = '0;
        w_data = '0;
        w_cmd  = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            if (r_grant[i]) begin
                w_gidx = PW'(i);
                w_data = req_data[8*i +: 8];
                w_cmd  = req_dc[i];
            end
        end
    end

    assign w_ptr_nxt   = (w_gidx == PW'(NREQ - 1)) ? '0 : w_gidx + PW'(1);
    assign w_grant_nxt = (r_state == ST_ARB) ? w_pick : r_grant;

    assign req_ready   = (r_state == ST_XFER && spi_avail) ? (req_valid & r_grant) : '0;
    assign spi_data    = (r_state == ST_XFER) ? w_data : 8'h00;
    assign spi_command = (r_state == ST_XFER) ? w_cmd : 1'b0;
    assign spi_start   = r_spi_start;
    assign grant       = r_grant;
    assign abort_err   = r_abort;

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:  if (w_any && r_rst_sync[1]) w_state_nxt = ST_ARB;
            ST_ARB:   w_state_nxt = w_any ? ST_XFER : ST_IDLE;
            ST_XFER:  if ((w_consume && w_glast) || w_timeout) w_state_nxt = ST_DRAIN;
            ST_DRAIN: if (!spi_busy) w_state_nxt = ST_GAP;
            ST_GAP:   w_state_nxt = ST_IDLE;
            default:  w_state_nxt = ST_IDLE;
        endcase
    end

    // r_rst_sync keeps IDLE from arbitrating in the first two cycles after reset release.
    always_ff @(posedge clock or negedge Reset) begin
        if (!Reset) begin
            r_state     <= ST_IDLE;
            r_grant     <= '0;
            r_ptr       <= '0;
            r_stall     <= '0;
            r_abort     <= 1'b0;
            r_spi_start <= 1'b0;
            r_rst_sync  <= 2'b00;
        end else begin
            r_rst_sync  <= {r_rst_sync[0], 1'b1};
            r_state     <= w_state_nxt;
            r_spi_start <= (w_state_nxt == ST_XFER) && |(req_valid & w_grant_nxt);
            if (r_state == ST_ARB && w_any)
                r_grant <= w_pick;
            if (r_state == ST_DRAIN && !spi_busy) begin
                r_grant <= '0;
                r_ptr   <= w_ptr_nxt;
            end
            if (r_state != ST_XFER || w_consume)
                r_stall <= '0;
            else if (w_stall)
                r_stall <= r_stall + SW'(1);
            if (w_timeout)
                r_abort <= 1'b1;
        end
    end

endmodule
